// File: rtl/histo_pkg.sv
// Shared definitions for the histogram readout path: controller states,
// the buffered beat format and the default datapath widths.
package histo_pkg;

    localparam int HISTO_DW = 8;
    localparam int HISTO_AW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [HISTO_DW-1:0] count;
        logic                last;
    } beat_t;

endpackage

// File: rtl/histo_readout_ctrl_fifo.sv
// Two-entry beat buffer between the bin RAM read return and the stream stage.
// Entry 0/1 are written alternately; the head entry is presented combinationally.
module histo_beat_fifo #(
    parameter int P_W = 9
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic           push_i,
    input  logic [P_W-1:0] push_data_i,
    input  logic           pop_i,
    output logic [P_W-1:0] head_o,
    output logic [1:0]     count_o
);

    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       do_pop;
    logic       do_push;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // A push into a full buffer is dropped; the controller's credit never lets it happen.
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);
    assign count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [P_W-1:0] data_q;
            always_ff @(posedge aclk or posedge areset) begin
                if (areset) begin
                    data_q <= '0;
                end else if (do_push && (wr_ptr_q == 1'(gi))) begin
                    data_q <= push_data_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    assign head_o  = rd_ptr_q ? g_entry[1].data_q : g_entry[0].data_q;
    assign count_o = count_q;

endmodule

// File: rtl/histo_readout_ctrl.sv
// Walks the histogram bin RAM from address 0 upward, streams each count as a
// beat (last on the top bin) and optionally clears every bin as it is read.
module histo_readout_ctrl
    import histo_pkg::*;
#(
    parameter int P_DW          = HISTO_DW,
    parameter int P_AW          = HISTO_AW,
    parameter bit P_CLR_ON_READ = 1'b1
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            mem_rd_en_o,
    output logic [P_AW-1:0] mem_rd_addr_o,
    input  logic [P_DW-1:0] mem_rd_data_i,
    output logic            mem_wr_en_o,
    output logic [P_AW-1:0] mem_wr_addr_o,
    output logic [P_DW-1:0] mem_wr_data_o,
    output logic [P_DW-1:0] histo_data_o,
    output logic            histo_data_valid_o,
    output logic            histo_data_last_o,
    input  logic            tready_i
);

    localparam logic [P_AW-1:0] LAST_ADDR = '1;

    rd_state_e       state_q, state_d;
    logic [P_AW-1:0] rd_addr_q, rd_addr_d;
    logic            done_q, done_d;
    logic            inflight_q;
    logic [P_AW-1:0] inflight_addr_q;

    logic [1:0]      fifo_count;
    logic [P_DW:0]   fifo_head;
    logic            fifo_valid;
    logic            pop;
    logic            rd_issue;
    logic [2:0]      credit_used;

    assign fifo_valid  = (fifo_count != 2'd0);
    assign pop         = fifo_valid && tready_i;
    // Slots the buffer will hold after this cycle, counting the read already in flight.
    assign credit_used = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    assign rd_issue    = (state_q == ST_RUN) && (credit_used < 3'd2);

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_RUN;
                    rd_addr_d = '0;
                end
            end
            ST_RUN: begin
                if (rd_issue) begin
                    if (rd_addr_q == LAST_ADDR) state_d = ST_FLUSH;
                    else rd_addr_d = rd_addr_q + P_AW'(1);
                end
            end
            ST_FLUSH: begin
                if (credit_used == 3'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q         <= ST_IDLE;
            rd_addr_q       <= '0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            done_q     <= done_d;
            inflight_q <= rd_issue;
            if (rd_issue) inflight_addr_q <= rd_addr_q;
        end
    end

    histo_beat_fifo #(
        .P_W(P_DW + 1)
    ) u_fifo (
        .aclk       (aclk),
        .areset     (areset),
        .push_i     (inflight_q),
        .push_data_i({mem_rd_data_i, (inflight_addr_q == LAST_ADDR)}),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count)
    );

    assign busy_o             = (state_q != ST_IDLE);
    assign done_o             = done_q;
    assign mem_rd_en_o        = rd_issue;
    assign mem_rd_addr_o      = rd_addr_q;
    // The clear lands in the return cycle, one address behind the read port.
    assign mem_wr_en_o        = inflight_q && P_CLR_ON_READ;
    assign mem_wr_addr_o      = inflight_addr_q;
    assign mem_wr_data_o      = '0;
    assign histo_data_valid_o = fifo_valid;
    assign histo_data_o       = fifo_valid ? fifo_head[P_DW:1] : '0;
    assign histo_data_last_o  = fifo_valid && fifo_head[0];

endmodule

// File: tb/tb_histo_readout_ctrl.sv
// Scoreboard bench: three configurations (P_AW=2 clear, P_AW=2 no clear,
// P_AW=8 clear) each run fixed, stalled, restart, mid-reset and random-ready readouts.
module tb_histo_readout_ctrl;
    import histo_pkg::*;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int finished = 0;

    logic [7:0] tbl [4] = '{8'd5, 8'd0, 8'd9, 8'd255};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cfg
            localparam int AW  = (gi == 2) ? 8 : 2;
            localparam int N   = 1 << AW;
            localparam bit CLR = (gi != 1);

            logic          areset;
            logic          start;
            logic          ready;
            logic          busy, done, rd_en, wr_en, valid, last;
            logic [AW-1:0] rd_addr, wr_addr;
            logic [7:0]    rd_data, wr_data, data;
            logic [63:0]   outs;
            logic [7:0]    ram        [N];
            logic [7:0]    init_bins  [N];
            logic [7:0]    model_mem  [N];
            logic          load_en = 1'b0;
            beat_t         exp_q [$];

            int   t0 = 0, mode = 0;
            int   beats_total = 0, dones_total = 0, wr_total = 0;
            int   base_beats = 0, base_dones = 0, base_wr = 0;
            int   done_cyc = -1, last_cyc = -1, rise_cyc = -1, max_occ = 0;
            logic done_busy = 1'b0, prev_valid = 1'b0, held = 1'b0;

            histo_readout_ctrl #(
                .P_DW         (8),
                .P_AW         (AW),
                .P_CLR_ON_READ(CLR)
            ) dut (
                .aclk              (aclk),
                .areset            (areset),
                .start_i           (start),
                .busy_o            (busy),
                .done_o            (done),
                .mem_rd_en_o       (rd_en),
                .mem_rd_addr_o     (rd_addr),
                .mem_rd_data_i     (rd_data),
                .mem_wr_en_o       (wr_en),
                .mem_wr_addr_o     (wr_addr),
                .mem_wr_data_o     (wr_data),
                .histo_data_o      (data),
                .histo_data_valid_o(valid),
                .histo_data_last_o (last),
                .tready_i          (ready)
            );

            assign outs = {{(42 - 2 * AW){1'b0}}, busy, done, rd_en, wr_en, valid, last,
                           rd_addr, wr_addr, wr_data, data};

            // Bin RAM: registered read, one write port.
            always @(posedge aclk) begin
                if (load_en) begin
                    for (int a = 0; a < N; a++) ram[a] <= init_bins[a];
                end else begin
                    if (rd_en) rd_data <= ram[rd_addr];
                    if (wr_en) ram[wr_addr] <= wr_data;
                end
            end

            task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
                checks++;
                if (act !== exp) begin
                    failures++;
                    $display("FAIL %s cfg=%0d got=%0h want=%0h", name, gi, act, exp);
                end
            endtask

            // Monitor: pops the scoreboard on every accepted beat.
            always @(negedge aclk) begin
                if (areset) begin
                    exp_q.delete();
                    held       = 1'b0;
                    prev_valid = 1'b0;
                end else begin
                    if (held) chk("valid_held", valid, 1);
                    if (valid && !prev_valid) rise_cyc = cyc;
                    if (valid) begin
                        if (exp_q.size() == 0) begin
                            chk("beat_unexpected", exp_q.size(), 1);
                        end else begin
                            chk("beat", {last, data}, {exp_q[0].last, exp_q[0].count});
                            if (ready) begin
                                $display("beat cfg=%0d cyc=%0d data=%0d last=%0b", gi, cyc, data, last);
                                void'(exp_q.pop_front());
                                beats_total++;
                                if (last) last_cyc = cyc;
                            end
                        end
                    end
                    if (done) begin
                        dones_total++;
                        done_cyc  = cyc;
                        done_busy = busy;
                    end
                    if (wr_en) wr_total++;
                    if (int'(dut.u_fifo.count_o) > max_occ) max_occ = int'(dut.u_fifo.count_o);
                    held       = valid && !ready;
                    prev_valid = valid;
                end
            end

            initial begin
                ready = 1'b1;
                forever begin
                    @(posedge aclk);
                    #1;
                    if (mode == 0) ready = 1'b1;
                    else if (mode == 1) ready = !((cyc >= t0 + 4) && (cyc <= t0 + 7));
                    else ready = 1'($urandom_range(0, 1));
                end
            end

            task automatic load_bins();
                for (int a = 0; a < N; a++) begin
                    init_bins[a] = (a < 4) ? tbl[a] : 8'($urandom_range(0, 255));
                    model_mem[a] = init_bins[a];
                end
                load_en = 1'b1;
                @(posedge aclk);
                #1;
                load_en = 1'b0;
            endtask

            // Expected stream: every bin in address order, last on the top bin.
            task automatic run_start();
                base_beats = beats_total;
                base_dones = dones_total;
                base_wr    = wr_total;
                for (int a = 0; a < N; a++) exp_q.push_back('{count: model_mem[a], last: (a == N - 1)});
                t0    = cyc;
                start = 1'b1;
                @(posedge aclk);
                #1;
                start = 1'b0;
            endtask

            task automatic wait_done();
                int budget;
                budget = 4 * N + 40;
                while ((dones_total == base_dones) && (budget > 0)) begin
                    @(posedge aclk);
                    #1;
                    budget--;
                end
                chk("done_timeout", dones_total - base_dones, 1);
                repeat (2) begin
                    @(posedge aclk);
                    #1;
                end
            endtask

            task automatic check_ram();
                for (int a = 0; a < N; a++) chk("ram_contents", ram[a], model_mem[a]);
            endtask

            task automatic finish_run();
                chk("beat_count", beats_total - base_beats, N);
                chk("done_count", dones_total - base_dones, 1);
                chk("queue_empty", exp_q.size(), 0);
                chk("fifo_occupancy_le2", max_occ <= 2, 1);
                chk("clear_writes", wr_total - base_wr, CLR ? N : 0);
                if (CLR) for (int a = 0; a < N; a++) model_mem[a] = 8'd0;
                check_ram();
                $display("run cfg=%0d start=%0d done=%0d beats=%0d", gi, t0, done_cyc, beats_total - base_beats);
            endtask

            initial begin
                areset = 1'b1;
                start  = 1'b0;
                repeat (3) @(posedge aclk);
                @(negedge aclk);
                chk("reset_outputs", outs, 0);
                @(posedge aclk);
                #1;
                areset = 1'b0;

                // Continuous ready: exact latency of first beat, last beat and done.
                load_bins();
                mode = 0;
                run_start();
                wait_done();
                chk("done_cycle", done_cyc, t0 + N + 3);
                chk("done_busy_low", done_busy, 0);
                chk("first_valid_cycle", rise_cyc, t0 + 3);
                chk("last_beat_cycle", last_cyc, t0 + N + 2);
                finish_run();

                // Four stalled cycles delay completion by exactly four.
                load_bins();
                mode = 1;
                run_start();
                wait_done();
                chk("stall_done_cycle", done_cyc, t0 + N + 7);
                finish_run();
                mode = 0;

                // Start mid-run is ignored; start in the done cycle is taken.
                load_bins();
                run_start();
                while (cyc < t0 + 4) begin
                    @(posedge aclk);
                    #1;
                end
                start = 1'b1;
                @(posedge aclk);
                #1;
                start = 1'b0;
                for (int i = 0; i < 4 * N + 40; i++) begin
                    @(negedge aclk);
                    if (done) break;
                end
                #1;
                chk("restart_done_seen", done, 1);
                chk("ignored_start_beats", beats_total - base_beats, N);
                chk("ignored_start_dones", dones_total - base_dones, 1);
                if (CLR) for (int a = 0; a < N; a++) model_mem[a] = 8'd0;
                run_start();
                wait_done();
                chk("restart_done_cycle", done_cyc, t0 + N + 3);
                finish_run();
                chk("idle_after_restart", busy, 0);

                // Reset in cycle 4: the first two bins are already cleared.
                load_bins();
                run_start();
                while (cyc < t0 + 4) begin
                    @(posedge aclk);
                    #1;
                end
                areset = 1'b1;
                @(negedge aclk);
                chk("midreset_outputs", outs, 0);
                @(posedge aclk);
                #1;
                areset = 1'b0;
                if (CLR) begin
                    model_mem[0] = 8'd0;
                    model_mem[1] = 8'd0;
                end
                check_ram();
                run_start();
                wait_done();
                finish_run();

                // Random backpressure.
                load_bins();
                mode = 2;
                run_start();
                wait_done();
                finish_run();
                mode = 0;

                finished++;
            end
        end
    endgenerate

    initial begin
        wait (finished == 3);
        repeat (2) @(posedge aclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog finished=%0d want=3", finished);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
